vga_vram_arbiter: RTL

//  Shares one single-port frame RAM between VGA scan-out reads and a drawing-engine write requester.

---
 rtl/vga_vram_pkg.sv | 16 +
 rtl/vram_wr_fifo.sv | 55 +++++
 rtl/vga_vram_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_vram_pkg.sv
// vga_vram_pkg: frame-buffer geometry defaults and the arbiter state encoding
// shared by the VRAM arbiter and its write FIFO.
package vga_vram_pkg;
    localparam int WIDTH      = 640;
    localparam int HEIGHT     = 480;
    localparam int FB_PIXELS  = WIDTH * HEIGHT;
    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } arbState_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous FIFO of {addr,data} write requests with full/empty
// flags; a push and a pop in the same cycle leave the occupancy unchanged.
module vram_wr_fifo #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushAddr,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [ADDR_W-1:0] popAddr,
    output logic [DATA_W-1:0] popData,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wrIdx;
    logic [PTR_W-1:0]         rdIdx;
    logic [CNT_W-1:0]         count;
    logic                     pushOk;
    logic                     popOk;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;
    assign {popAddr, popData} = mem[rdIdx];

    always_ff @(posedge clk25) begin
        if (pushOk) mem[wrIdx] <= {pushAddr, pushData};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk25) begin
        if (reset) begin
            wrIdx <= '0;
            rdIdx <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrIdx <= wrIdx + 1'b1;
            if (popOk)  rdIdx <= rdIdx + 1'b1;
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: scan-out reads own the frame RAM on active cycles; queued writes drain in blanking.
// Defining VGA_VRAM_STATS_EN adds the stall_cnt/drop_cnt statistics outputs.
module vga_vram_arbiter #(
    parameter int WIDTH      = vga_vram_pkg::WIDTH,
    parameter int HEIGHT     = vga_vram_pkg::HEIGHT,
    parameter int DATA_W     = vga_vram_pkg::DATA_W,
    parameter int ADDR_W     = vga_vram_pkg::ADDR_W,
    parameter int FIFO_DEPTH = vga_vram_pkg::FIFO_DEPTH
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              active,
    input  logic              screenEnd,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
`ifdef VGA_VRAM_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [7:0]        drop_cnt
`endif
);
    import vga_vram_pkg::*;

    // state | meaning
    // IDLE  | blanking, no queued write; RAM address held, no write
    // SCAN  | visible pixel; RAM read issued at rdPtr
    // DRAIN | blanking; one queued write issued (dropped if out of range)

    localparam logic [ADDR_W-1:0] fbPixels = ADDR_W'(WIDTH * HEIGHT);

    arbState_t         state;
    logic [ADDR_W-1:0] rdPtr;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] popAddr;
    logic [DATA_W-1:0] popData;

    assign wr_ready = !fifoFull && !reset;
    assign push     = wr_valid && wr_ready;
    assign pop      = !active && !fifoEmpty && !reset;

    vram_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) uFifo (
        .clk25    (clk25),
        .reset    (reset),
        .push     (push),
        .pushAddr (wr_addr),
        .pushData (wr_data),
        .pop      (pop),
        .popAddr  (popAddr),
        .popData  (popData),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk25) begin
        if (reset) begin
            state     <= IDLE;
            rdPtr     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else begin
            if (screenEnd)   rdPtr <= '0;
            else if (active) rdPtr <= rdPtr + 1'b1;

            if (active) begin
                state    <= SCAN;
                mem_addr <= rdPtr;
                mem_we   <= 1'b0;
            end else if (!fifoEmpty) begin
                state     <= DRAIN;
                mem_addr  <= popAddr;
                mem_wdata <= popData;
                mem_we    <= (popAddr < fbPixels);
            end else begin
                state  <= IDLE;
                mem_we <= 1'b0;
            end

            // A SCAN state marks the cycle the RAM is presenting scan data.
            pix_data  <= mem_rdata;
            pix_valid <= (state == SCAN);
        end
    end

`ifdef VGA_VRAM_STATS_EN
    always_ff @(posedge clk25) begin
        if (reset || screenEnd) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 1'b1;
            if (pop && popAddr >= fbPixels && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif
endmodule
